mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file.
- Consumes the two register read operands (rs/rt) for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers, which feed the writeback mux for MFHI/MFLO.
- Control stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  launch the operation selected by op
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  input  WIDTH  operand A (multiplicand / dividend)
- rt_data  input  WIDTH  operand B (multiplier / divisor)
- mthi  input  1  write rs_data into HI
- mtlo  input  1  write rs_data into LO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - Reset mid-operation aborts the operation; no partial result is ever written.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 at edge E0 latches the operand magnitudes. For signed ops, the sign flags are rs[W-1] and rt[W-1]; for unsigned ops the flags are 0.
  - Also at E0: counter=0, state goes to ITER, busy=1.
  - mthi/mtlo are honoured only in IDLE with start=0. They update HI/LO at the edge; done stays 0.
  - start together with mthi or mtlo: start wins and mthi/mtlo are ignored.
- ITER:
  - One radix-2 step per cycle:
    - Multiply: shift-add over a 2*WIDTH accumulator.
    - Divide: restoring divide with a WIDTH-bit partial remainder.
  - The counter increments each step. After WIDTH steps (edge E_WIDTH) the state goes to FIX.
- FIX (one cycle):
  - Sign correction:
    - Product is negated if the sign flags differ.
    - Quotient is negated if the sign flags differ.
    - Remainder takes the dividend's sign.
  - At the next edge: HI/LO are written, state goes to IDLE, busy=0, done=1 for exactly one cycle.
- Latency:
  - busy is high for WIDTH+1 cycles (33 at default).
  - Results and done are visible after edge E(WIDTH+1).
  - A new start is accepted in the done cycle.
- Result mapping:
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits of the full 2*WIDTH product.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (rt=0, DIV or DIVU): HI=rs_data as sampled at E0, LO=all ones. Same latency as a normal divide unless the optional feature is enabled.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no exception.
- start, mthi or mtlo while busy: ignored. Operands and op are not resampled.
- hi/lo hold their values at all times except at a completion edge or an mthi/mtlo edge.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - At E0, if op is a multiply and either operand is 0, or op is a divide and rt=0, the state goes directly to FIX and skips ITER.
  - FIX loads the final result: 0:0 for multiply, the divide-by-zero values for divide.
  - busy is high for 1 cycle; done follows after E1.
- Undefined: every operation takes the full WIDTH+1 cycles. No zero-detect logic is synthesised.

Test Plan:
- Reset: assert rst_n=0 mid-MULT at cycle 10 -> hi=0, lo=0, busy=0 immediately; after release a new MULTU 3*5 gives lo=15, hi=0.
- MULT 0xFFFFFFFE * 0x00000003 (-2*3) -> busy high 33 cycles, then done pulse 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 (0xFFFFFFF9, 0x2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU 0x1234 / 0 -> hi=0x1234, lo=0xFFFFFFFF. With MDU_EARLY_OUT_EN: done after 2 edges; without it: after 33.
- Busy interlock: start MULTU 6*7, pulse start/mthi with other operands at cycles 5 and 20 -> ignored, final lo=42. Start issued in the done cycle is accepted.
- MTHI/MTLO in idle: mthi, rs=0xAAAA5555 -> hi updated next edge, done=0. start+mtlo same cycle -> mtlo ignored, operation runs.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// ============================================================================
// mult_div_unit_if : operand/result bundle between the register file and the
//                    iterative multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// Optional macro MDU_EARLY_OUT_EN skips iteration for zero operands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mult_div_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_sa;
  logic               r_sb;
  logic               r_bzero;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_init;
  logic [1:0]         w_start_state;
  logic [WIDTH-1:0]   w_acc_hi;
  logic [WIDTH-1:0]   w_acc_lo;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_sub;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_signed = ~bus.op[0];
  assign w_sa     = w_signed & bus.rs_data[WIDTH-1];
  assign w_sb     = w_signed & bus.rt_data[WIDTH-1];
  assign w_mag_a  = w_sa ? -bus.rs_data : bus.rs_data;
  assign w_mag_b  = w_sb ? -bus.rt_data : bus.rt_data;

  // Accumulator low half holds the multiplier (multiply) or the dividend
  // shifting out while quotient bits shift in (divide).
`ifdef MDU_EARLY_OUT_EN
  logic w_early;
  assign w_early = bus.op[1] ? (bus.rt_data == '0)
                             : ((bus.rs_data == '0) || (bus.rt_data == '0));
  assign w_start_state = w_early ? S_FIX : S_ITER;
  assign w_acc_init    = w_early ? (bus.op[1] ? {w_mag_a, {WIDTH{1'b1}}} : '0)
                                 : (bus.op[1] ? {{WIDTH{1'b0}}, w_mag_a}
                                              : {{WIDTH{1'b0}}, w_mag_b});
`else
  assign w_start_state = S_ITER;
  assign w_acc_init    = bus.op[1] ? {{WIDTH{1'b0}}, w_mag_a}
                                   : {{WIDTH{1'b0}}, w_mag_b};
`endif

  assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo = r_acc[WIDTH-1:0];

  assign w_sum   = {1'b0, w_acc_hi} + {1'b0, (r_acc[0] ? r_m : {WIDTH{1'b0}})};
  assign w_shift = {w_acc_hi, w_acc_lo[WIDTH-1]};
  assign w_sub   = (w_shift >= {1'b0, r_m});
  // The true difference is below the divisor, so WIDTH bits never truncate it.
  assign w_diff  = w_shift[WIDTH-1:0] - r_m;

  assign w_step = r_is_div
                ? (w_sub ? {w_diff, w_acc_lo[WIDTH-2:0], 1'b1}
                         : {w_shift[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b0})
                : {w_sum, w_acc_lo[WIDTH-1:1]};

  assign w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_fix_hi = r_is_div ? (r_sa ? -w_acc_hi : w_acc_hi) : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? (r_bzero ? {WIDTH{1'b1}}
                                        : ((r_sa ^ r_sb) ? -w_acc_lo : w_acc_lo))
                             : w_prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_bzero  <= 1'b0;
      r_m      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= w_start_state;
            r_cnt    <= '0;
            r_is_div <= bus.op[1];
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_bzero  <= bus.op[1] & (bus.rt_data == '0);
            r_m      <= bus.op[1] ? w_mag_b : w_mag_a;
            r_acc    <= w_acc_init;
          end else begin
            if (bus.mthi) r_hi <= bus.rs_data;
            if (bus.mtlo) r_lo <= bus.rs_data;
          end
        end
        S_ITER: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire
